// File: rtl/instr_fetch.sv
`default_nettype none
// instr_fetch: owns the PC, issues one-cycle-latency word reads and buffers {pc, instr} in a FIFO for decode.
// A redirect flushes the FIFO and any in-flight word; fetch restarts at the new PC on the following cycle.
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instruction,
   output logic [31:0] instr_pc
);
   localparam int unsigned AW      = $clog2(QDEPTH);
   localparam int unsigned CW      = $clog2(QDEPTH + 1);
   localparam logic [CW:0] C_DEPTH = (CW + 1)'(QDEPTH);

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          inflight_q, inflight_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] head_q, head_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [31:0]   fifo_pc_q    [QDEPTH];
   logic [31:0]   fifo_instr_q [QDEPTH];

   logic          issue;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;
   logic          unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Occupancy counts the in-flight word so a full FIFO can never be overrun; a same-cycle pop is not credited.
   assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
   assign issue       = rst_n && !redirect_valid && (occupancy < C_DEPTH);
   assign push        = inflight_q && !redirect_valid;
   assign pop         = instr_valid && instr_ready;

   assign imem_req    = issue;
   assign imem_addr   = pc_q;
   assign instr_valid = (count_q != '0);
   assign instruction = instr_valid ? fifo_instr_q[head_q] : 32'h0;
   assign instr_pc    = instr_valid ? fifo_pc_q[head_q]    : 32'h0;

   always_comb begin
      pc_d          = pc_q;
      inflight_d    = issue;
      inflight_pc_d = issue ? pc_q : inflight_pc_q;
      count_d       = count_q;
      head_d        = head_q;
      tail_d        = tail_q;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         inflight_d = 1'b0;
         count_d    = '0;
         head_d     = '0;
         tail_d     = '0;
      end else begin
         if (issue) begin
            pc_d = pc_q + 32'd4;
         end
         if (push) begin
            tail_d = tail_q + AW'(1);
         end
         if (pop) begin
            head_d = head_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= 32'h0;
         count_q       <= '0;
         head_q        <= '0;
         tail_q        <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         count_q       <= count_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
      end
   end

   // Storage needs no reset: entries are only observed while count_q covers them.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_pc_q[tail_q]    <= inflight_pc_q;
         fifo_instr_q[tail_q] <= imem_rdata;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// tb_instr_fetch: scoreboard bench; expected fetch PCs are queued on request and retired as decode pops them.
module tb_instr_fetch;
   localparam int unsigned QDEPTH   = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] instr_pc;

   logic        rst_w_n;
   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata = 32'h0;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] sb_q[$];
   bit          m_infl;
   logic [31:0] m_pc;
   bit          e_req;
   bit          e_valid;

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .instr_pc(instr_pc)
   );

   instr_fetch #(.RESET_PC(WRAP_PC), .QDEPTH(QDEPTH)) u_wrap (
      .clk(clk), .rst_n(rst_w_n),
      .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .instr_valid(w_valid), .instr_ready(1'b1),
      .instruction(w_instr), .instr_pc(w_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle-latency memories; garbage when no request so stale captures show up.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      w_rdata    <= w_req    ? mem_word(w_addr)    : 32'hDEAD_BEEF;
   end

   // Reference model: sb_q holds FIFO entries followed by the in-flight request (if m_infl).
   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_req",   {31'b0, imem_req},    32'h0);
         check("rst_addr",  imem_addr,            RESET_PC);
         check("rst_valid", {31'b0, instr_valid}, 32'h0);
         check("rst_instr", instruction,          32'h0);
         check("rst_pc",    instr_pc,             32'h0);
         sb_q.delete();
         m_infl = 1'b0;
         m_pc   = RESET_PC;
      end else begin
         e_req   = !redirect_valid && (sb_q.size() < QDEPTH);
         e_valid = (int'(sb_q.size()) - int'(m_infl)) > 0;
         check("req", {31'b0, imem_req}, {31'b0, e_req});
         if (e_req) check("addr", imem_addr, m_pc);
         check("valid", {31'b0, instr_valid}, {31'b0, e_valid});
         if (e_valid) begin
            check("head_pc",    instr_pc,    sb_q[0]);
            check("head_instr", instruction, mem_word(sb_q[0]));
         end else begin
            check("idle_instr", instruction, 32'h0);
            check("idle_pc",    instr_pc,    32'h0);
         end
         check("overflow", {31'b0, (dut.count_q == QDEPTH) && dut.push && !dut.pop}, 32'h0);
         if (redirect_valid) begin
            sb_q.delete();
            m_infl = 1'b0;
            m_pc   = {redirect_pc[31:2], 2'b00};
         end else begin
            if (e_valid && instr_ready) void'(sb_q.pop_front());
            if (e_req) begin
               sb_q.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
            m_infl = e_req;
         end
      end
   end

   initial begin
      logic [31:0] wrap_exp[3];
      int k;
      int got;
      rst_n          = 1'b0;
      rst_w_n        = 1'b0;
      instr_ready    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      step(3);
      rst_n = 1'b1;
      step(10);

      instr_ready = 1'b0;
      step(10);
      instr_ready = 1'b1;
      step(8);

      // Build 3 buffered entries plus one in flight, then redirect with dirty low bits.
      instr_ready = 1'b0;
      k = 0;
      while (!(sb_q.size() == 4 && m_infl) && k < 20) begin
         step(1);
         k++;
      end
      check("fill_bound", {31'b0, k < 20}, 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0107;
      step(1);
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      step(8);

      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      step(1);
      redirect_pc    = 32'h0000_0300;
      step(1);
      redirect_valid = 1'b0;
      step(8);

      repeat (60) begin
         instr_ready    = 1'($urandom_range(0, 1));
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = $urandom & 32'h0000_0FFF;
         step(1);
      end
      redirect_valid = 1'b0;
      instr_ready    = 1'b1;
      step(4);

      instr_ready = 1'b0;
      step(8);
      rst_n = 1'b0;
      step(1);
      rst_n       = 1'b1;
      instr_ready = 1'b1;
      step(10);

      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      rst_w_n = 1'b1;
      got = 0;
      for (int i = 0; i < 10 && got < 3; i++) begin
         @(negedge clk);
         if (w_valid) begin
            check("wrap_pc",    w_pc,    wrap_exp[got]);
            check("wrap_instr", w_instr, mem_word(wrap_exp[got]));
            got++;
         end
      end
      check("wrap_count", got, 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit that produces the 32-bit instruction stream consumed by `decode`. It owns the PC, issues word reads to a one-cycle-latency instruction memory, and buffers returned words in a small FIFO. It presents instructions to decode with a valid/ready handshake and supports a single-cycle redirect/flush from branch resolution. When no instruction is available it drives all-zero instruction bits, which decode treats as a NOP.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `QDEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read strobe to instruction memory.
- `imem_addr`  out  32  byte address of the read; bits [1:0] always 0.
- `imem_rdata`  in  32  read data, valid exactly one cycle after `imem_req`.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored (treated as 0).
- `instr_valid`  out  1  FIFO head holds a valid instruction.
- `instr_ready`  in  1  decode accepts the head this cycle.
- `instruction`  out  32  head instruction; 32'h0 when `instr_valid`=0.
- `instr_pc`  out  32  PC of head instruction; 32'h0 when `instr_valid`=0.

## Operation
- State: `pc` (next fetch address), `inflight` (1 bit, request issued last cycle), `inflight_pc`, FIFO of {pc, instr} with `count`, head/tail pointers wrapping modulo QDEPTH.
- Issue: `imem_req` = `rst_n` released AND !`redirect_valid` AND (`count` + `inflight`) < QDEPTH. The check is conservative and does not credit a same-cycle pop. `imem_addr` = `pc`. On issue, `pc` ← `pc` + 4 (32-bit wrap: 32'hFFFF_FFFC → 0) and `inflight` ← 1. Otherwise `inflight` ← 0.
- Capture: when `inflight`=1 and no redirect this cycle, push {`inflight_pc`, `imem_rdata`} at the tail.
- Pop: when `instr_valid` && `instr_ready`, advance the head. Push and pop in the same cycle leave `count` unchanged.
- Redirect (priority over everything):
  - Clear the FIFO (`count`←0, pointers←0).
  - Discard any in-flight response; `inflight`←0.
  - `pc` ← {`redirect_pc`[31:2], 2'b00}.
  - No request in the redirect cycle. The first request at the new PC goes out the following cycle.
  - A pop in the redirect cycle is still considered consumed by decode. The FIFO is cleared regardless.
- `instr_valid` = (`count` != 0). `instruction` and `instr_pc` come combinationally from the head, gated to 0 when empty.
- The FIFO cannot overflow by construction. An overflow condition is a bug; the bench must assert it never occurs.

## Timing
- Reset (async assert, sync-to-clk release): `pc`=RESET_PC, `count`=0, `inflight`=0. `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instruction`=0, `instr_pc`=0.
- Reset mid-operation: all state returns to reset values immediately. Any response arriving after release is ignored because `inflight`=0.
- First cycle after release (C0): `imem_req`=1 at RESET_PC. C1: data captured at the end of C1. C2: `instr_valid`=1.
- Fetch-to-valid latency is 2 cycles. Redirect-to-valid latency is 3 cycles (redirect cycle, request cycle, capture cycle).
- Steady state with `instr_ready` held high: one instruction per cycle after the initial latency; `count` settles at 1.
- With `instr_ready` low: fetch continues until `count` + `inflight` = QDEPTH. It then stalls with the FIFO full, and `imem_addr` holds the next PC.

## Test plan
- Reset release, memory returns word = address, ready=1: instr_pc/instruction = 0/0x0 (valid), 4/0x4, 8/0x8 on consecutive cycles from C2. First valid cycle is C2.
- Ready low for 10 cycles: exactly QDEPTH=4 requests issued (addr 0,4,8,C), then `imem_req`=0. Raising ready drains 0,4,8,C in order, back-to-back, with fetch resuming at 0x10.
- Redirect to 0x104 (bits [1:0] forced, input 0x107) while the FIFO holds 3 entries and a request is in flight: FIFO empties next cycle and the in-flight word is dropped. Next `imem_addr`=0x104; first valid instr_pc=0x104, 3 cycles after the redirect.
- Redirect asserted on two consecutive cycles (0x200, then 0x300): only 0x300 onward is delivered; no word from 0x200 ever appears valid.
- PC wrap: RESET_PC=0xFFFF_FFF8, ready=1 → delivered pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n asserted for one cycle mid-stream with the FIFO full: outputs read 0 during reset. After release, fetch restarts at RESET_PC and no pre-reset word is ever delivered.
